// File: rtl/vector_mem_unit.sv
// Vector load/store sequencer: moves one LANES x WORD_W vector between the register file
// and word-wide data memory, one lane per memory handshake, for VLD and VST.
module vector_mem_unit #(
    parameter int LANES  = 16,
    parameter int WORD_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [3:0]                opcode,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LANES*WORD_W-1:0]   st_vec,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [WORD_W-1:0]         mem_wdata,
    input  logic                      mem_ack,
    input  logic [WORD_W-1:0]         mem_rdata,
    output logic                      busy,
    output logic                      done,
    output logic [LANES*WORD_W-1:0]   ld_vec
);

    localparam int VW    = LANES * WORD_W;
    localparam int IDX_W = $clog2(LANES);

    localparam logic [3:0]       OP_VLD   = 4'b0100;
    localparam logic [3:0]       OP_VST   = 4'b0101;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   base_q;
    logic [VW-1:0]       st_vec_q;
    logic [VW-1:0]       ld_buf_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [WORD_W-1:0]   mem_wdata_q;
    logic                busy_q;
    logic                done_q;
    logic [VW-1:0]       ld_vec_q;

    logic [IDX_W-1:0]    idx_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic [WORD_W-1:0]   mem_wdata_d;
    logic [VW-1:0]       ld_buf_d;
    logic                op_valid;

    assign op_valid = (opcode == OP_VLD) || (opcode == OP_VST);

    // Next-lane request and the load buffer with the current lane merged in; the merged
    // copy lets the final lane reach ld_vec on the same edge that enters DONE.
    always_comb begin
        idx_d       = idx_q + 1'b1;
        mem_addr_d  = base_q + ADDR_W'(idx_d);
        mem_wdata_d = st_vec_q[idx_d*WORD_W +: WORD_W];
        ld_buf_d    = ld_buf_q;
        ld_buf_d[idx_q*WORD_W +: WORD_W] = mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            st_vec_q    <= '0;
            ld_buf_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ld_vec_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && op_valid) begin
                        base_q      <= base_addr;
                        st_vec_q    <= st_vec;
                        idx_q       <= '0;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (opcode == OP_VST);
                        mem_addr_q  <= base_addr;
                        mem_wdata_q <= st_vec[WORD_W-1:0];
                        busy_q      <= 1'b1;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // mem_we_q doubles as the latched operation type for the whole transfer.
                    if (mem_ack) begin
                        if (!mem_we_q) begin
                            ld_buf_q <= ld_buf_d;
                        end
                        if (idx_q == LAST_IDX) begin
                            if (!mem_we_q) begin
                                ld_vec_q <= ld_buf_d;
                            end
                            mem_req_q <= 1'b0;
                            mem_we_q  <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_DONE;
                        end else begin
                            idx_q       <= idx_d;
                            mem_addr_q  <= mem_addr_d;
                            mem_wdata_q <= mem_wdata_d;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ld_vec    = ld_vec_q;

endmodule

// File: tb/tb_vector_mem_unit.sv
// Directed bench for vector_mem_unit: a word-addressed memory model answers requests, and each
// scenario task checks the request stream, done timing and ld_vec against hand-built expectations.
module tb_vector_mem_unit;

    localparam int LANES  = 16;
    localparam int WORD_W = 16;
    localparam int ADDR_W = 16;
    localparam int VW     = LANES * WORD_W;

    localparam logic [3:0] OP_VLD  = 4'b0100;
    localparam logic [3:0] OP_VST  = 4'b0101;
    localparam logic [3:0] OP_VADD = 4'b0000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [3:0]        opcode = '0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [VW-1:0]     st_vec = '0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [WORD_W-1:0] mem_rdata;
    logic              busy;
    logic              done;
    logic [VW-1:0]     ld_vec;

    logic [WORD_W-1:0] mem [0:65535];
    logic [VW-1:0]     expLd = '0;
    int                nChecks = 0;
    int                nFails = 0;
    int                ackMode = 0;
    int                cyc = 0;

    vector_mem_unit #(.LANES(LANES), .WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start), .opcode(opcode), .base_addr(base_addr),
        .st_vec(st_vec), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy),
        .done(done), .ld_vec(ld_vec)
    );

    always #5 clk = ~clk;

    // Memory model: read data is combinational on the current address, writes land on an acked edge.
    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_req && mem_ack && mem_we) mem[mem_addr] = mem_wdata;
    end

    // Acknowledge generator, changing 2 time units after each rising edge:
    // mode 0 holds ack high, mode 1 raises it every third cycle.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            mem_ack = (ackMode == 0) ? 1'b1 : ((cyc % 3) == 0);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [3:0] op, input logic [ADDR_W-1:0] base,
                                 input logic [VW-1:0] vec);
        @(negedge clk);
        start = 1'b1; opcode = op; base_addr = base; st_vec = vec;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #3;
        nChecks++; if (mem_req !== 1'b0)  begin nFails++; $display("[TB] FAIL reset mem_req: got %b want 0", mem_req); end
        nChecks++; if (mem_we !== 1'b0)   begin nFails++; $display("[TB] FAIL reset mem_we: got %b want 0", mem_we); end
        nChecks++; if (mem_addr !== 16'h0000) begin nFails++; $display("[TB] FAIL reset mem_addr: got %h want 0000", mem_addr); end
        nChecks++; if (mem_wdata !== 16'h0000) begin nFails++; $display("[TB] FAIL reset mem_wdata: got %h want 0000", mem_wdata); end
        nChecks++; if (busy !== 1'b0)     begin nFails++; $display("[TB] FAIL reset busy: got %b want 0", busy); end
        nChecks++; if (done !== 1'b0)     begin nFails++; $display("[TB] FAIL reset done: got %b want 0", done); end
        nChecks++; if (ld_vec !== '0)     begin nFails++; $display("[TB] FAIL reset ld_vec: got %h want 0", ld_vec); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nChecks++; if (mem_req !== 1'b0)  begin nFails++; $display("[TB] FAIL post_reset mem_req: got %b want 0", mem_req); end
    endtask

    task automatic test_vst_basic();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = 16'(16'h1000 + i);
        ackMode = 0;
        applyStimulus(OP_VST, 16'h0100, v);
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            nChecks++; if (mem_req !== 1'b1) begin nFails++; $display("[TB] FAIL vst req c%0d: got %b want 1", i + 1, mem_req); end
            nChecks++; if (mem_we !== 1'b1)  begin nFails++; $display("[TB] FAIL vst we c%0d: got %b want 1", i + 1, mem_we); end
            nChecks++; if (mem_addr !== 16'(16'h0100 + i)) begin nFails++; $display("[TB] FAIL vst addr c%0d: got %h want %h", i + 1, mem_addr, 16'(16'h0100 + i)); end
            nChecks++; if (mem_wdata !== 16'(16'h1000 + i)) begin nFails++; $display("[TB] FAIL vst wdata c%0d: got %h want %h", i + 1, mem_wdata, 16'(16'h1000 + i)); end
            nChecks++; if (busy !== 1'b1 || done !== 1'b0) begin nFails++; $display("[TB] FAIL vst busy/done c%0d: got %b/%b want 1/0", i + 1, busy, done); end
        end
        @(negedge clk);
        nChecks++; if (done !== 1'b1 || busy !== 1'b1 || mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL vst done c17: got done=%b busy=%b req=%b want 1/1/0", done, busy, mem_req); end
        nChecks++; if (ld_vec !== expLd) begin nFails++; $display("[TB] FAIL vst ld_vec: got %h want %h", ld_vec, expLd); end
        @(negedge clk);
        nChecks++; if (done !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL vst idle c18: got done=%b busy=%b want 0/0", done, busy); end
        for (int i = 0; i < LANES; i++) begin
            nChecks++; if (mem[16'(16'h0100 + i)] !== 16'(16'h1000 + i)) begin nFails++; $display("[TB] FAIL vst memword %0d: got %h want %h", i, mem[16'(16'h0100 + i)], 16'(16'h1000 + i)); end
        end
    endtask

    task automatic test_vld_basic();
        logic [VW-1:0] expNew;
        for (int i = 0; i < LANES; i++) begin
            mem[16'(16'h0200 + i)] = 16'(16'hA000 + i);
            expNew[i*WORD_W +: WORD_W] = 16'(16'hA000 + i);
        end
        ackMode = 0;
        applyStimulus(OP_VLD, 16'h0200, '0);
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            nChecks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL vld req/we c%0d: got %b/%b want 1/0", i + 1, mem_req, mem_we); end
            nChecks++; if (mem_addr !== 16'(16'h0200 + i)) begin nFails++; $display("[TB] FAIL vld addr c%0d: got %h want %h", i + 1, mem_addr, 16'(16'h0200 + i)); end
            nChecks++; if (ld_vec !== expLd) begin nFails++; $display("[TB] FAIL vld early ld_vec c%0d: got %h want %h", i + 1, ld_vec, expLd); end
            nChecks++; if (done !== 1'b0) begin nFails++; $display("[TB] FAIL vld early done c%0d: got %b want 0", i + 1, done); end
        end
        @(negedge clk);
        expLd = expNew;
        nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL vld done c17: got %b want 1", done); end
        nChecks++; if (ld_vec !== expLd) begin nFails++; $display("[TB] FAIL vld ld_vec: got %h want %h", ld_vec, expLd); end
        @(negedge clk);
        nChecks++; if (done !== 1'b0 || ld_vec !== expLd) begin nFails++; $display("[TB] FAIL vld hold c18: got done=%b ld_vec=%h want 0/%h", done, ld_vec, expLd); end
    endtask

    task automatic test_vld_stall();
        logic [VW-1:0] expNew;
        int hs = 0;
        int doneCnt = 0;
        int tail = -1;
        bit timedOut = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            mem[16'(16'h0300 + i)] = 16'(16'hC000 + 3 * i);
            expNew[i*WORD_W +: WORD_W] = 16'(16'hC000 + 3 * i);
        end
        ackMode = 1;
        applyStimulus(OP_VLD, 16'h0300, '0);
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (tail < 0 && hs < LANES) begin
                nChecks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin nFails++; $display("[TB] FAIL stall req/we hs%0d: got %b/%b want 1/0", hs, mem_req, mem_we); end
                nChecks++; if (mem_addr !== 16'(16'h0300 + hs)) begin nFails++; $display("[TB] FAIL stall addr hs%0d: got %h want %h", hs, mem_addr, 16'(16'h0300 + hs)); end
                nChecks++; if (ld_vec !== expLd) begin nFails++; $display("[TB] FAIL stall early ld_vec hs%0d: got %h want %h", hs, ld_vec, expLd); end
                if (mem_ack) hs++;
            end
            if (done) begin
                doneCnt++;
                if (tail < 0) tail = c;
                nChecks++; if (ld_vec !== expNew) begin nFails++; $display("[TB] FAIL stall ld_vec: got %h want %h", ld_vec, expNew); end
            end
            if (tail >= 0 && c >= tail + 3) begin
                timedOut = 1'b0;
                break;
            end
        end
        expLd = expNew;
        ackMode = 0;
        nChecks++; if (timedOut) begin nFails++; $display("[TB] FAIL stall timeout: got no completion want done within 120 cycles"); end
        nChecks++; if (hs !== LANES) begin nFails++; $display("[TB] FAIL stall handshakes: got %0d want %0d", hs, LANES); end
        nChecks++; if (doneCnt !== 1) begin nFails++; $display("[TB] FAIL stall done count: got %0d want 1", doneCnt); end
    endtask

    task automatic test_vst_wrap();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = 16'(16'hB000 + i);
        ackMode = 0;
        applyStimulus(OP_VST, 16'hFFF8, v);
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            nChecks++; if (mem_addr !== 16'(16'hFFF8 + i)) begin nFails++; $display("[TB] FAIL wrap addr c%0d: got %h want %h", i + 1, mem_addr, 16'(16'hFFF8 + i)); end
            nChecks++; if (mem_wdata !== 16'(16'hB000 + i)) begin nFails++; $display("[TB] FAIL wrap wdata c%0d: got %h want %h", i + 1, mem_wdata, 16'(16'hB000 + i)); end
        end
        @(negedge clk);
        nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL wrap done c17: got %b want 1", done); end
        @(negedge clk);
        nChecks++; if (mem[16'h0000] !== 16'hB008 || mem[16'h0007] !== 16'hB00F) begin nFails++; $display("[TB] FAIL wrap low words: got %h/%h want b008/b00f", mem[16'h0000], mem[16'h0007]); end
        nChecks++; if (mem[16'hFFF8] !== 16'hB000 || mem[16'hFFFF] !== 16'hB007) begin nFails++; $display("[TB] FAIL wrap high words: got %h/%h want b000/b007", mem[16'hFFF8], mem[16'hFFFF]); end
        nChecks++; if (ld_vec !== expLd) begin nFails++; $display("[TB] FAIL wrap ld_vec: got %h want %h", ld_vec, expLd); end
    endtask

    task automatic test_ignored_ops();
        logic [VW-1:0] v;
        int doneCnt = 0;
        for (int i = 0; i < LANES; i++) v[i*WORD_W +: WORD_W] = 16'(16'h7000 + i);
        ackMode = 0;
        applyStimulus(OP_VADD, 16'h0400, v);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            nChecks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin nFails++; $display("[TB] FAIL vadd ignored c%0d: got req=%b busy=%b done=%b want 0/0/0", c, mem_req, busy, done); end
        end
        applyStimulus(OP_VST, 16'h0500, v);
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 2) begin
                start = 1'b1; opcode = OP_VLD; base_addr = 16'h0600;
            end else begin
                start = 1'b0;
            end
            if (mem_req) begin
                nChecks++; if (mem_we !== 1'b1 || mem_addr[15:8] !== 8'h05) begin nFails++; $display("[TB] FAIL busy_start stream c%0d: got we=%b addr=%h want 1/05xx", c, mem_we, mem_addr); end
            end
            if (done) doneCnt++;
        end
        nChecks++; if (doneCnt !== 1) begin nFails++; $display("[TB] FAIL busy_start done count: got %0d want 1", doneCnt); end
        nChecks++; if (busy !== 1'b0 || mem_req !== 1'b0) begin nFails++; $display("[TB] FAIL busy_start idle: got busy=%b req=%b want 0/0", busy, mem_req); end
        nChecks++; if (ld_vec !== expLd) begin nFails++; $display("[TB] FAIL busy_start ld_vec: got %h want %h", ld_vec, expLd); end
    endtask

    task automatic test_reset_midop();
        logic [VW-1:0] expNew;
        for (int i = 0; i < LANES; i++) begin
            mem[16'(16'h0700 + i)] = 16'(16'h3300 + i);
            expNew[i*WORD_W +: WORD_W] = 16'(16'hA000 + i);
        end
        ackMode = 0;
        applyStimulus(OP_VLD, 16'h0700, '0);
        for (int i = 0; i < 6; i++) @(negedge clk);
        nChecks++; if (mem_addr !== 16'h0705) begin nFails++; $display("[TB] FAIL midrst addr idx5: got %h want 0705", mem_addr); end
        #1 rst = 1'b1;
        #1;
        expLd = '0;
        nChecks++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin nFails++; $display("[TB] FAIL midrst outputs: got req=%b busy=%b done=%b want 0/0/0", mem_req, busy, done); end
        nChecks++; if (ld_vec !== expLd) begin nFails++; $display("[TB] FAIL midrst ld_vec: got %h want 0", ld_vec); end
        nChecks++; if (mem_addr !== 16'h0000) begin nFails++; $display("[TB] FAIL midrst addr: got %h want 0000", mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        nChecks++; if (mem_req !== 1'b0 || busy !== 1'b0) begin nFails++; $display("[TB] FAIL midrst after release: got req=%b busy=%b want 0/0", mem_req, busy); end
        applyStimulus(OP_VLD, 16'h0200, '0);
        for (int i = 0; i < LANES; i++) begin
            @(negedge clk);
            nChecks++; if (mem_addr !== 16'(16'h0200 + i)) begin nFails++; $display("[TB] FAIL midrst reload addr c%0d: got %h want %h", i + 1, mem_addr, 16'(16'h0200 + i)); end
        end
        @(negedge clk);
        expLd = expNew;
        nChecks++; if (done !== 1'b1) begin nFails++; $display("[TB] FAIL midrst reload done: got %b want 1", done); end
        nChecks++; if (ld_vec !== expLd) begin nFails++; $display("[TB] FAIL midrst reload ld_vec: got %h want %h", ld_vec, expLd); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vst_basic();
        test_vld_basic();
        test_vld_stall();
        test_vst_wrap();
        test_ignored_ops();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
